// File: rtl/tdm_demux4.sv
// 1-to-4 time-division demultiplexer: steers round-robin samples to channels 0..3
// and presents each completed frame as one registered, double-buffered update.
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             out_valid,
    output logic [1:0]       sel,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] stage_q [3];
    logic [WIDTH-1:0] stage_d [3];
    logic [WIDTH-1:0] out_q   [4];
    logic [WIDTH-1:0] out_d   [4];
    logic             out_valid_q, out_valid_d;
    logic             sync_err_q, sync_err_d;

    // NOTE: every variable gets a hold-value default before any branch, so no latches are inferred.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        stage_d     = stage_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (in_sof) begin
                        stage_d[0] = in_data;
                        sel_d      = 2'd1;
                        state_d    = LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_sof) begin
                        // SOF mid-frame abandons the partial frame but still resyncs on this beat.
                        sync_err_d = (sel_q != 2'd0);
                        stage_d[0] = in_data;
                        sel_d      = 2'd1;
                    end else begin
                        unique case (sel_q)
                            2'd0: begin
                                sync_err_d = 1'b1;
                                state_d    = HUNT;
                            end
                            2'd1: begin
                                stage_d[1] = in_data;
                                sel_d      = 2'd2;
                            end
                            2'd2: begin
                                stage_d[2] = in_data;
                                sel_d      = 2'd3;
                            end
                            2'd3: begin
                                out_d[0]    = stage_q[0];
                                out_d[1]    = stage_q[1];
                                out_d[2]    = stage_q[2];
                                out_d[3]    = in_data;
                                out_valid_d = 1'b1;
                                sel_d       = 2'd0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the small staging and output
    // arrays are reset too, so a reset mid-frame leaves nothing stale behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            sel_q       <= 2'd0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            for (int i = 0; i < 3; i++) stage_q[i] <= '0;
            for (int i = 0; i < 4; i++) out_q[i]   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
            stage_q     <= stage_d;
            out_q       <= out_d;
        end
    end

    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];
    assign out_valid = out_valid_q;
    assign sel       = sel_q;
    assign locked    = (state_q == LOCKED);
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 with hand-computed expectations.
module tb_tdm_demux4;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic [WIDTH-1:0] out0, out1, out2, out3;
    logic             out_valid;
    logic [1:0]       sel;
    logic             locked;
    logic             sync_err;

    int n_compared   = 0;
    int n_mismatched = 0;

    tdm_demux4 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .sel       (sel),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One beat presented for exactly one rising edge; returns 1 time unit after that edge.
    task automatic beat(input logic sof, input logic [WIDTH-1:0] data);
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'hEE;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        check({tag, ".out0"}, 32'(out0), 32'(e0));
        check({tag, ".out1"}, 32'(out1), 32'(e1));
        check({tag, ".out2"}, 32'(out2), 32'(e2));
        check({tag, ".out3"}, 32'(out3), 32'(e3));
    endtask

    initial begin
        // Reset state
        #3;
        check_outs("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.sel",       32'(sel),       32'd0);
        check("rst.locked",    32'(locked),    32'd0);
        check("rst.sync_err",  32'(sync_err),  32'd0);
        #9 rst = 1'b0;

        // Basic frame on consecutive cycles
        beat(1'b1, 8'h11);
        check("f1.locked", 32'(locked), 32'd1);
        check("f1.sel1",   32'(sel),    32'd1);
        beat(1'b0, 8'h22);
        beat(1'b0, 8'h33);
        check("f1.sel3",      32'(sel),       32'd3);
        check("f1.noval3",    32'(out_valid), 32'd0);
        check("f1.noleak",    32'(out0),      32'd0);
        beat(1'b0, 8'h44);
        check_outs("f1", 8'h11, 8'h22, 8'h33, 8'h44);
        check("f1.out_valid", 32'(out_valid), 32'd1);
        check("f1.sel0",      32'(sel),       32'd0);
        check("f1.sync_err",  32'(sync_err),  32'd0);
        idle(1);
        check("f1.pulse_end", 32'(out_valid), 32'd0);

        // Same frame with 3-cycle gaps
        beat(1'b1, 8'h11);
        idle(3);
        check("gap.sel_hold1", 32'(sel),       32'd1);
        check("gap.noval1",    32'(out_valid), 32'd0);
        beat(1'b0, 8'h22);
        idle(3);
        check("gap.sel_hold2", 32'(sel),       32'd2);
        beat(1'b0, 8'h33);
        idle(3);
        check("gap.sel_hold3", 32'(sel),       32'd3);
        check("gap.noval3",    32'(out_valid), 32'd0);
        beat(1'b0, 8'h44);
        check_outs("gap", 8'h11, 8'h22, 8'h33, 8'h44);
        check("gap.out_valid", 32'(out_valid), 32'd1);
        idle(1);
        check("gap.pulse_end", 32'(out_valid), 32'd0);

        // Back-to-back frames
        beat(1'b1, 8'hA0);
        beat(1'b0, 8'hA1);
        beat(1'b0, 8'hA2);
        beat(1'b0, 8'hA3);
        check_outs("b2bA", 8'hA0, 8'hA1, 8'hA2, 8'hA3);
        check("b2bA.out_valid", 32'(out_valid), 32'd1);
        beat(1'b1, 8'hB0);
        check("b2bB0.out_valid", 32'(out_valid), 32'd0);
        check("b2bB0.sel",       32'(sel),       32'd1);
        check("b2bB0.sync_err",  32'(sync_err),  32'd0);
        beat(1'b0, 8'hB1);
        beat(1'b0, 8'hB2);
        check_outs("b2bB2.hold", 8'hA0, 8'hA1, 8'hA2, 8'hA3);
        check("b2bB2.out_valid", 32'(out_valid), 32'd0);
        beat(1'b0, 8'hB3);
        check_outs("b2bB", 8'hB0, 8'hB1, 8'hB2, 8'hB3);
        check("b2bB.out_valid", 32'(out_valid), 32'd1);

        // Early SOF
        beat(1'b1, 8'h01);
        beat(1'b0, 8'h02);
        check("esof.no_err_yet", 32'(sync_err), 32'd0);
        beat(1'b1, 8'h10);
        check("esof.sync_err",  32'(sync_err),  32'd1);
        check("esof.out_valid", 32'(out_valid), 32'd0);
        check("esof.sel",       32'(sel),       32'd1);
        check("esof.locked",    32'(locked),    32'd1);
        check_outs("esof.hold", 8'hB0, 8'hB1, 8'hB2, 8'hB3);
        beat(1'b0, 8'h20);
        check("esof.err_end", 32'(sync_err), 32'd0);
        beat(1'b0, 8'h30);
        check("esof.noval", 32'(out_valid), 32'd0);
        beat(1'b0, 8'h40);
        check_outs("esof", 8'h10, 8'h20, 8'h30, 8'h40);
        check("esof.out_valid", 32'(out_valid), 32'd1);
        check("esof.no_err",    32'(sync_err),  32'd0);

        // Missing SOF at sel = 0
        beat(1'b0, 8'h55);
        check("msof.sync_err",  32'(sync_err),  32'd1);
        check("msof.locked",    32'(locked),    32'd0);
        check("msof.sel",       32'(sel),       32'd0);
        check("msof.out_valid", 32'(out_valid), 32'd0);
        check_outs("msof.hold", 8'h10, 8'h20, 8'h30, 8'h40);
        beat(1'b0, 8'h77);
        check("hunt.no_err", 32'(sync_err), 32'd0);
        check("hunt.sel",    32'(sel),      32'd0);
        check("hunt.locked", 32'(locked),   32'd0);
        beat(1'b1, 8'h66);
        check("relock.locked", 32'(locked), 32'd1);
        beat(1'b0, 8'h67);
        beat(1'b0, 8'h68);
        beat(1'b0, 8'h69);
        check_outs("relock", 8'h66, 8'h67, 8'h68, 8'h69);
        check("relock.out_valid", 32'(out_valid), 32'd1);

        // Asynchronous reset mid-frame, between edges
        beat(1'b1, 8'hC0);
        beat(1'b0, 8'hC1);
        #3 rst = 1'b1;
        #1;
        check_outs("arst", 8'h00, 8'h00, 8'h00, 8'h00);
        check("arst.sel",    32'(sel),    32'd0);
        check("arst.locked", 32'(locked), 32'd0);
        #2 rst = 1'b0;
        beat(1'b0, 8'hD1);
        check("arst.hunt_sel",    32'(sel),    32'd0);
        check("arst.hunt_locked", 32'(locked), 32'd0);
        check("arst.hunt_err",    32'(sync_err), 32'd0);
        beat(1'b0, 8'hD2);
        beat(1'b1, 8'hE0);
        beat(1'b0, 8'hE1);
        beat(1'b0, 8'hE2);
        check("arst.noval", 32'(out_valid), 32'd0);
        beat(1'b0, 8'hE3);
        check_outs("arst.frame", 8'hE0, 8'hE1, 8'hE2, 8'hE3);
        check("arst.out_valid", 32'(out_valid), 32'd1);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
